coco_spi_master: RTL and testbench

COCO_SPI_MASTER -- requirements
Module: coco_spi_master

---
 rtl/coco_spi_master_pkg.sv | 47 ++++
 rtl/coco_spi_master_spi_byte_master.sv | 75 +++++++
 rtl/coco_spi_master.sv | 152 +++++++++++++++
 tb/tb_coco_spi_master.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/coco_spi_master_pkg.sv
// Shared definitions for the coco SPI master: op codes, SPI command bytes,
// register window bounds and sequencer states.
package coco_spi_master_pkg;

  localparam logic [2:0] OP_ADDR   = 3'd1;
  localparam logic [2:0] OP_WRITE  = 3'd2;
  localparam logic [2:0] OP_READ   = 3'd3;
  localparam logic [2:0] OP_STATUS = 3'd4;
  localparam logic [2:0] OP_DEVCON = 3'd5;

  localparam logic [7:0] CMD_ADDR   = 8'h01;
  localparam logic [7:0] CMD_WRITE  = 8'h02;
  localparam logic [7:0] CMD_READ   = 8'h03;
  localparam logic [7:0] CMD_STATUS = 8'h04;
  localparam logic [7:0] CMD_DEVCON = 8'h05;

  localparam logic [15:0] WIN_LO = 16'hFF40;
  localparam logic [15:0] WIN_HI = 16'hFF5F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_GAP,
    ST_DONE
  } state_e;

  function automatic logic [7:0] cmd_byte(input logic [2:0] op);
    case (op)
      OP_ADDR:   cmd_byte = CMD_ADDR;
      OP_WRITE:  cmd_byte = CMD_WRITE;
      OP_READ:   cmd_byte = CMD_READ;
      OP_STATUS: cmd_byte = CMD_STATUS;
      OP_DEVCON: cmd_byte = CMD_DEVCON;
      default:   cmd_byte = 8'h00;
    endcase
  endfunction

  function automatic logic op_legal(input logic [2:0] op);
    op_legal = (op >= OP_ADDR) && (op <= OP_DEVCON);
  endfunction

  function automatic logic in_window(input logic [15:0] addr);
    in_window = (addr >= WIN_LO) && (addr <= WIN_HI);
  endfunction

endpackage

// File: rtl/coco_spi_master_spi_byte_master.sv
// Single SPI mode-0 byte exchange: ss lead half-period, 8 SCLK periods,
// one trailing low half-period, then ss released and done pulsed.
module spi_byte_master #(
  parameter int CLK_DIV = 6
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [7:0] tx_i,
  input  logic       miso_i,
  output logic       done_o,
  output logic [7:0] rx_o,
  output logic       sclk_o,
  output logic       mosi_o,
  output logic       ss_o
);
  localparam int CW = $clog2(CLK_DIV + 1);

  logic          busy_q;
  logic [CW-1:0] cnt_q;
  logic [4:0]    half_q;
  logic [7:0]    tx_q;
  logic [7:0]    rx_q;
  logic          sclk_q;
  logic          ss_q;
  logic          half_end;

  assign half_end = (cnt_q == CW'(CLK_DIV - 1));
  assign done_o   = busy_q && half_end && (half_q == 5'd17);
  assign rx_o     = rx_q;
  assign sclk_o   = sclk_q;
  assign mosi_o   = tx_q[7];
  assign ss_o     = ss_q;

  // Halves 1,3..15 are SCLK high (rising edge entering them), 2..16 low.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= 1'b0;
      ss_q   <= 1'b1;
      sclk_q <= 1'b0;
      cnt_q  <= '0;
      half_q <= '0;
      tx_q   <= 8'h00;
    end else if (!busy_q) begin
      if (start_i) begin
        busy_q <= 1'b1;
        ss_q   <= 1'b0;
        cnt_q  <= '0;
        half_q <= '0;
        tx_q   <= tx_i;
      end
    end else if (half_end) begin
      cnt_q  <= '0;
      half_q <= half_q + 5'd1;
      if (half_q == 5'd17) begin
        busy_q <= 1'b0;
        ss_q   <= 1'b1;
      end else if (!half_q[0] && (half_q < 5'd15)) begin
        sclk_q <= 1'b1;
      end else if (half_q[0]) begin
        sclk_q <= 1'b0;
        tx_q   <= {tx_q[6:0], 1'b0};
      end
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (busy_q && half_end && !half_q[0] && (half_q < 5'd15)) begin
      rx_q <= {rx_q[6:0], miso_i};
    end
  end

endmodule

// File: rtl/coco_spi_master.sv
// Command-level SPI master: turns one request into a sequence of framed bytes,
// skipping the address prefix when the shadow address already matches.
module coco_spi_master
  import coco_spi_master_pkg::*;
#(
  parameter int CLK_DIV = 6,
  parameter int GAP     = 32
) (
  input  logic        clock_50,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_data,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso,
  output logic        ss
);
  localparam int GW = $clog2(GAP + 1);

  state_e        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [2:0]    last_q, last_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [2:0]    op_q;
  logic [15:0]   addr_q;
  logic [7:0]    data_q;
  logic          addr_valid_q;
  logic [15:0]   shadow_q;
  logic [7:0]    rsp_data_q;
  logic          start;
  logic          byte_done;
  logic [7:0]    rx_byte;
  logic [7:0]    cur_byte;
  logic          needs_prefix;
  logic          fin;

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_DONE);
  assign rsp_data  = rsp_data_q;
  assign fin       = (state_q == ST_GAP) && (gap_q == '0) && (idx_q == last_q);

  assign needs_prefix = (req_op == OP_ADDR) ||
                        (((req_op == OP_WRITE) || (req_op == OP_READ)) &&
                         !(addr_valid_q && (shadow_q == req_addr)));

  // Byte slots: 0..2 address prefix, 3 command, 4 payload/dummy.
  always_comb begin
    cur_byte = 8'h00;
    case (idx_q)
      3'd0:    cur_byte = CMD_ADDR;
      3'd1:    cur_byte = addr_q[15:8];
      3'd2:    cur_byte = addr_q[7:0];
      3'd3:    cur_byte = cmd_byte(op_q);
      3'd4:    cur_byte = (op_q == OP_WRITE)  ? data_q :
                          (op_q == OP_DEVCON) ? {4'h0, data_q[3:0]} : 8'h00;
      default: cur_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    gap_d   = gap_q;
    start   = 1'b0;
    unique case (state_q)
      ST_IDLE: if (req_valid) begin
        state_d = ST_LOAD;
        idx_d   = needs_prefix ? 3'd0 : 3'd3;
        last_d  = (req_op == OP_ADDR) ? 3'd2 : 3'd4;
      end
      ST_LOAD: if (!op_legal(op_q)) begin
        state_d = ST_DONE;
      end else begin
        start   = 1'b1;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: if (byte_done) begin
        state_d = ST_GAP;
        gap_d   = GW'(GAP - 2);
      end
      ST_GAP: if (gap_q == '0) begin
        if (idx_q == last_q) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = ST_LOAD;
        end
      end else begin
        gap_d = gap_q - GW'(1);
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_50) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      last_q       <= '0;
      gap_q        <= '0;
      addr_valid_q <= 1'b0;
      shadow_q     <= 16'hFFFF;
      rsp_data_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      gap_q   <= gap_d;
      if ((state_q == ST_SHIFT) && byte_done && (idx_q == 3'd2)) begin
        shadow_q     <= addr_q;
        addr_valid_q <= 1'b1;
      end
      if (fin && ((op_q == OP_WRITE) || (op_q == OP_READ)) && !in_window(addr_q)) begin
        shadow_q <= shadow_q + 16'd1;
      end
      if (fin) begin
        rsp_data_q <= ((op_q == OP_READ) || (op_q == OP_STATUS)) ? rx_byte : 8'h00;
      end else if ((state_q == ST_LOAD) && !op_legal(op_q)) begin
        rsp_data_q <= 8'h00;
      end
    end
  end

  always_ff @(posedge clock_50) begin
    if (req_valid && req_ready) begin
      op_q   <= req_op;
      addr_q <= req_addr;
      data_q <= req_data;
    end
  end

  spi_byte_master #(.CLK_DIV(CLK_DIV)) u_byte (
    .clk_i   (clock_50),
    .rst_i   (reset),
    .start_i (start),
    .tx_i    (cur_byte),
    .miso_i  (miso),
    .done_o  (byte_done),
    .rx_o    (rx_byte),
    .sclk_o  (sclk),
    .mosi_o  (mosi),
    .ss_o    (ss)
  );

endmodule

// File: tb/tb_coco_spi_master.sv
// Directed bench for coco_spi_master: SPI slave model decodes mosi bytes,
// returns a programmable byte on miso, and each step is checked in line.
module tb_coco_spi_master;
  localparam int CLK_DIV = 6;
  localparam int GAP     = 32;

  logic        clock_50 = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [15:0] req_addr;
  logic [7:0]  req_data;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        sclk;
  logic        mosi;
  logic        miso;
  logic        ss;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mon_q[$];
  int         ss_lows = 0;
  int         bitcnt  = 0;
  int         rsp_cnt = 0;
  logic [7:0] shreg   = 8'h00;
  logic [7:0] sbit    = 8'h00;
  logic [7:0] slave_byte = 8'h00;
  logic       ss_prev = 1'b1;
  logic       sclk_prev = 1'b0;

  coco_spi_master #(.CLK_DIV(CLK_DIV), .GAP(GAP)) dut (
    .clock_50  (clock_50),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .sclk      (sclk),
    .mosi      (mosi),
    .miso      (miso),
    .ss        (ss)
  );

  always #10 clock_50 = ~clock_50;

  assign miso = sbit[7];

  // SPI slave/monitor: load reply at ss fall, shift on SCLK fall, capture on rise.
  always @(ss or sclk) begin
    if (ss !== ss_prev) begin
      if (ss === 1'b0) begin
        ss_lows++;
        bitcnt = 0;
        sbit   = slave_byte;
      end else if (ss === 1'b1 && bitcnt == 8) begin
        mon_q.push_back(shreg);
      end
    end
    if (sclk !== sclk_prev && ss === 1'b0) begin
      if (sclk === 1'b1) begin
        shreg = {shreg[6:0], mosi};
        bitcnt++;
      end else if (sclk === 1'b0) begin
        sbit = {sbit[6:0], 1'b0};
      end
    end
    ss_prev   = ss;
    sclk_prev = sclk;
  end

  always @(negedge clock_50) if (rsp_valid === 1'b1) rsp_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_seq(input string tag, input int base, input int n, input logic [39:0] exp);
    logic [7:0] e;
    logic [7:0] o;
    chk($sformatf("%s_nbytes", tag), mon_q.size() - base, n);
    for (int i = 0; i < n; i++) begin
      e = exp[39 - 8*i -: 8];
      o = (base + i < mon_q.size()) ? mon_q[base + i] : 8'hxx;
      chk($sformatf("%s_byte%0d", tag, i), o, e);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [15:0] addr, input logic [7:0] data);
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      @(negedge clock_50);
      n++;
    end
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_data  = data;
    @(posedge clock_50);
    #1;
    req_valid = 1'b0;
    req_op    = 3'd6;
    req_addr  = 16'hDEAD;
    req_data  = 8'hEE;
  endtask

  task automatic do_op(input logic [2:0] op, input logic [15:0] addr, input logic [7:0] data,
                       output int lat);
    issue(op, addr, data);
    lat = 0;
    while (lat < 3000) begin
      @(negedge clock_50);
      lat++;
      if (rsp_valid === 1'b1) break;
    end
    if (rsp_valid !== 1'b1) begin
      checks++;
      failures++;
      $error("FAIL rsp_timeout observed=none expected=rsp_valid");
    end
    @(negedge clock_50);
    chk("rsp_one_cycle", rsp_valid, 1'b0);
  endtask

  initial begin
    int lat, b, s0, r0, n;
    reset = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_addr = 16'h0; req_data = 8'h0;
    repeat (3) @(negedge clock_50);
    chk("rst_ss", ss, 1'b1);
    chk("rst_sclk", sclk, 1'b0);
    chk("rst_mosi", mosi, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_data", rsp_data, 8'h00);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_addr_valid", dut.addr_valid_q, 1'b0);
    chk("rst_shadow", dut.shadow_q, 16'hFFFF);
    reset = 1'b0;
    @(negedge clock_50);

    b = mon_q.size(); s0 = ss_lows; r0 = rsp_cnt;
    do_op(3'd2, 16'h1234, 8'hA5, lat);
    check_seq("wr1", b, 5, 40'h01_12_34_02_A5);
    chk("wr1_ss_lows", ss_lows - s0, 5);
    chk("wr1_rsp_cnt", rsp_cnt - r0, 1);
    chk("wr1_shadow", dut.shadow_q, 16'h1235);

    b = mon_q.size();
    do_op(3'd2, 16'h1235, 8'h5A, lat);
    check_seq("wr2_short", b, 2, 40'h02_5A_00_00_00);

    slave_byte = 8'h81; b = mon_q.size();
    do_op(3'd3, 16'hFF48, 8'h00, lat);
    check_seq("rd1", b, 5, 40'h01_FF_48_03_00);
    chk("rd1_data", rsp_data, 8'h81);

    slave_byte = 8'h3C; b = mon_q.size();
    do_op(3'd3, 16'hFF48, 8'h00, lat);
    check_seq("rd2_short", b, 2, 40'h03_00_00_00_00);
    chk("rd2_data", rsp_data, 8'h3C);

    slave_byte = 8'h04; b = mon_q.size();
    do_op(3'd4, 16'h0000, 8'h00, lat);
    check_seq("status", b, 2, 40'h04_00_00_00_00);
    chk("status_data", rsp_data, 8'h04);
    chk("status_latency", lat, 281);

    b = mon_q.size();
    do_op(3'd5, 16'h0000, 8'hF7, lat);
    check_seq("devcon", b, 2, 40'h05_07_00_00_00);
    chk("devcon_data", rsp_data, 8'h00);
    chk("devcon_shadow", dut.shadow_q, 16'hFF48);

    b = mon_q.size();
    do_op(3'd2, 16'hFFFF, 8'h11, lat);
    check_seq("wr_ffff", b, 5, 40'h01_FF_FF_02_11);
    b = mon_q.size();
    do_op(3'd2, 16'h0000, 8'h22, lat);
    check_seq("wr_wrap", b, 2, 40'h02_22_00_00_00);

    b = mon_q.size(); s0 = ss_lows;
    do_op(3'd7, 16'h1111, 8'h33, lat);
    chk("illegal_latency", lat, 2);
    chk("illegal_ss_lows", ss_lows - s0, 0);
    chk("illegal_data", rsp_data, 8'h00);

    b = mon_q.size();
    do_op(3'd1, 16'h4000, 8'h00, lat);
    check_seq("addr_op", b, 3, 40'h01_40_00_00_00);
    chk("addr_op_shadow", dut.shadow_q, 16'h4000);
    b = mon_q.size();
    do_op(3'd2, 16'h4000, 8'h33, lat);
    check_seq("wr_after_addr", b, 2, 40'h02_33_00_00_00);

    s0 = ss_lows; r0 = rsp_cnt;
    issue(3'd2, 16'h4001, 8'h99);
    n = 0;
    while (!(ss_lows == s0 + 2 && bitcnt == 4) && n < 2000) begin
      @(negedge clock_50);
      n++;
    end
    if (n >= 2000) begin
      checks++;
      failures++;
      $error("FAIL abort_wait observed=timeout expected=bit4_of_byte2");
    end
    reset = 1'b1;
    @(posedge clock_50);
    #1;
    chk("abort_ss", ss, 1'b1);
    chk("abort_sclk", sclk, 1'b0);
    @(negedge clock_50);
    reset = 1'b0;
    chk("abort_addr_valid", dut.addr_valid_q, 1'b0);
    chk("abort_req_ready", req_ready, 1'b1);
    repeat (300) @(negedge clock_50);
    chk("abort_no_rsp", rsp_cnt - r0, 0);
    b = mon_q.size();
    do_op(3'd2, 16'h4001, 8'h77, lat);
    check_seq("post_abort", b, 5, 40'h01_40_01_02_77);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
